// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch controller and its neighbours.
// Holds FSM state encoding, PC step and the prediction-buffer update bundle.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // idx carries the full word address; consumers keep the low bits they need
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [29:0] idx;
  } bpb_update_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Next-PC priority mux for fetch.
// Order: redirect, predicted target, sequential, hold.
module fetch_ctrl_next_pc_sel
  import fetch_ctrl_pkg::*;
(
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        accept,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = align_pc(redirect_pc);
    end else if (accept && pred_taken) begin
      next_pc = align_pc(pred_target);
    end else if (accept) begin
      next_pc = align_pc(pc + PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: PC register, stall/flush FSM, redirect counting
// and registered commit-side history / prediction-buffer updates.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned IDX_BITS     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iq_full,
  input  logic                pred_taken,
  input  logic [31:0]         pred_target,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                br_commit_valid,
  input  logic                br_commit_taken,
  input  logic [31:0]         br_commit_pc,
  output logic [31:0]         pc,
  output logic                fetch_valid,
  output logic                flush,
  output logic                hist_update,
  output logic                hist_bit,
  output logic                bpb_update_valid,
  output logic                bpb_update_taken,
  output logic [IDX_BITS-1:0] bpb_update_idx,
  output logic [31:0]         mispredict_count
);

  fetch_state_e state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic [31:0]  next_pc;
  bpb_update_t  upd;

  fetch_ctrl_next_pc_sel u_sel (
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .accept         (fetch_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pc             (pc),
    .next_pc        (next_pc)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    unique case (state)
      RUN: begin
        fetch_valid = !iq_full && !redirect_valid;
        if (iq_full) state_n = STALL;
      end
      STALL: begin
        if (!iq_full) state_n = RUN;
      end
      FLUSH: begin
        flush = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = iq_full ? STALL : RUN;
      end
      default: state_n = RUN;
    endcase
    // redirect overrides whatever the current state wanted
    if (redirect_valid) begin
      state_n = FLUSH;
      cnt_n   = 4'(FLUSH_CYCLES);
    end
    if (reset) begin
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      cnt              <= 4'd0;
      pc               <= align_pc(RESET_PC);
      mispredict_count <= 32'd0;
      upd              <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pc    <= next_pc;
      if (redirect_valid && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
      upd.valid <= br_commit_valid;
      upd.taken <= br_commit_taken;
      upd.idx   <= br_commit_pc[31:2];
    end
  end

  assign hist_update      = upd.valid;
  assign hist_bit         = upd.taken;
  assign bpb_update_valid = upd.valid;
  assign bpb_update_taken = upd.taken;
  assign bpb_update_idx   = upd.idx[IDX_BITS-1:0];

  logic unused_bits;
  assign unused_bits = ^{upd.idx, br_commit_pc[1:0]};

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario bench for fetch_ctrl: per-cycle expectations go into a
// scoreboard when inputs are driven and are compared at the falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iq_full = 1'b0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        br_commit_valid = 1'b0;
  logic        br_commit_taken = 1'b0;
  logic [31:0] br_commit_pc = '0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        hist_update;
  logic        hist_bit;
  logic        bpb_update_valid;
  logic        bpb_update_taken;
  logic [9:0]  bpb_update_idx;
  logic [31:0] mispredict_count;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        fl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2),
    .IDX_BITS     (10)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .iq_full          (iq_full),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .br_commit_valid  (br_commit_valid),
    .br_commit_taken  (br_commit_taken),
    .br_commit_pc     (br_commit_pc),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .flush            (flush),
    .hist_update      (hist_update),
    .hist_bit         (hist_bit),
    .bpb_update_valid (bpb_update_valid),
    .bpb_update_taken (bpb_update_taken),
    .bpb_update_idx   (bpb_update_idx),
    .mispredict_count (mispredict_count)
  );

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || fetch_valid !== e.fv || flush !== e.fl)
        $display("FAIL cycle t=%0t: pc=%h fv=%b flush=%b, want pc=%h fv=%b flush=%b",
                 $time, pc, fetch_valid, flush, e.pc, e.fv, e.fl);
      else
        passed++;
    end
  end

  task automatic drive(input logic iqf, input logic pt, input logic [31:0] tgt,
                       input logic rv, input logic [31:0] rpc,
                       input logic [31:0] epc, input logic efv, input logic efl);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    iq_full        = iqf;
    pred_taken     = pt;
    pred_target    = tgt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.pc = epc;
    e.fv = efv;
    e.fl = efl;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b0 ||
        mispredict_count !== 32'h0 || hist_update !== 1'b0 || bpb_update_valid !== 1'b0)
      $display("FAIL reset: pc=%h fv=%b flush=%b cnt=%0d hist=%b bpb=%b, want 0s",
               pc, fetch_valid, flush, mispredict_count, hist_update, bpb_update_valid);
    else
      passed++;
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h4, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h8, 1, 0);
  endtask

  task automatic test_pred;
    drive(0, 0, 0, 0, 0, 32'hC, 1, 0);
    drive(0, 1, 32'h200, 0, 0, 32'h10, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h200, 1, 0);
    drive(0, 1, 32'h40, 0, 0, 32'h204, 1, 0);
  endtask

  task automatic test_stall;
    drive(1, 1, 32'hBAD0, 0, 0, 32'h40, 0, 0);
    drive(1, 1, 32'hBAD0, 0, 0, 32'h40, 0, 0);
    drive(1, 0, 0, 0, 0, 32'h40, 0, 0);
    drive(0, 1, 32'hBAD0, 0, 0, 32'h40, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h40, 1, 0);
    drive(0, 1, 32'h80, 0, 0, 32'h44, 1, 0);
  endtask

  task automatic test_redirect;
    drive(0, 1, 32'hBAD0, 1, 32'h1000, 32'h80, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h1000, 0, 1);
    total++;
    if (mispredict_count !== 32'd1)
      $display("FAIL redirect_count: got %0d, want 1", mispredict_count);
    else
      passed++;
    drive(0, 0, 0, 0, 0, 32'h1000, 0, 1);
    drive(0, 0, 0, 0, 0, 32'h1000, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h1004, 1, 0);
  endtask

  task automatic test_priority;
    drive(1, 0, 0, 0, 0, 32'h1008, 0, 0);
    drive(0, 0, 0, 1, 32'h1800, 32'h1008, 0, 0);
    drive(0, 1, 32'hDEAD0000, 0, 0, 32'h1800, 0, 1);
    drive(0, 1, 32'hDEAD0000, 1, 32'h2000, 32'h1800, 0, 1);
    drive(0, 1, 32'hDEAD0000, 0, 0, 32'h2000, 0, 1);
    drive(0, 0, 0, 0, 0, 32'h2000, 0, 1);
    drive(0, 0, 0, 0, 0, 32'h2000, 1, 0);
    total++;
    if (mispredict_count !== 32'd3)
      $display("FAIL priority_count: got %0d, want 3", mispredict_count);
    else
      passed++;
  endtask

  task automatic test_commit;
    drive(0, 0, 0, 1, 32'h3000, 32'h2004, 0, 0);
    br_commit_valid = 1'b1;
    br_commit_taken = 1'b1;
    br_commit_pc    = 32'h0000_0ABC;
    drive(0, 0, 0, 0, 0, 32'h3000, 0, 1);
    br_commit_valid = 1'b1;
    br_commit_taken = 1'b0;
    br_commit_pc    = 32'h0000_03FC;
    total++;
    if (hist_update !== 1'b1 || hist_bit !== 1'b1 || bpb_update_valid !== 1'b1 ||
        bpb_update_taken !== 1'b1 || bpb_update_idx !== 10'h2AF)
      $display("FAIL commit_taken: hu=%b hb=%b bv=%b bt=%b idx=%h, want 1 1 1 1 2af",
               hist_update, hist_bit, bpb_update_valid, bpb_update_taken, bpb_update_idx);
    else
      passed++;
    drive(0, 0, 0, 0, 0, 32'h3000, 0, 1);
    br_commit_valid = 1'b0;
    br_commit_taken = 1'b1;
    br_commit_pc    = 32'hFFFF_FFFF;
    total++;
    if (hist_update !== 1'b1 || hist_bit !== 1'b0 || bpb_update_valid !== 1'b1 ||
        bpb_update_taken !== 1'b0 || bpb_update_idx !== 10'h0FF)
      $display("FAIL commit_not_taken: hu=%b hb=%b bv=%b bt=%b idx=%h, want 1 0 1 0 0ff",
               hist_update, hist_bit, bpb_update_valid, bpb_update_taken, bpb_update_idx);
    else
      passed++;
    drive(0, 0, 0, 0, 0, 32'h3000, 1, 0);
    total++;
    if (hist_update !== 1'b0 || bpb_update_valid !== 1'b0 || mispredict_count !== 32'd4)
      $display("FAIL commit_idle: hu=%b bv=%b cnt=%0d, want 0 0 4",
               hist_update, bpb_update_valid, mispredict_count);
    else
      passed++;
  endtask

  task automatic test_wrap;
    drive(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h3004, 0, 0);
    drive(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
    drive(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
    drive(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    drive(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
    total++;
    if (mispredict_count !== 32'd5)
      $display("FAIL wrap_count: got %0d, want 5", mispredict_count);
    else
      passed++;
  endtask

  initial begin
    test_reset();
    test_pred();
    test_stall();
    test_redirect();
    test_priority();
    test_commit();
    test_wrap();
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0)
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
